// File: rtl/printf_pkg.sv
// Shared frame layout and FSM encoding for the printf trace stage.
package printf_pkg;

  localparam logic [7:0]  DFLT_HDR_BYTE = 8'hA5;
  localparam int unsigned FRAME_BYTES   = 22;
  localparam int unsigned DATA_BYTES    = 20;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned ENTRY_W       = 8 + 5 * WORD_W;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StHdr,
    StSeq,
    StData
  } state_e;

  // Data byte idx (0..19) of a snapshot; words go out MSB byte first.
  function automatic logic [7:0] data_byte(input logic [ENTRY_W-1:0] entry,
                                           input logic [4:0] idx);
    logic [4:0] rev;
    rev = 5'(DATA_BYTES - 1) - idx;
    return entry[{rev, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/printf_trace_fifo.sv
// Single-clock snapshot FIFO with occupancy count; push is honoured when full if a pop coincides.
module printf_trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/printf_trace.sv
// Snapshots the printf observation buses into a FIFO and streams each as a 22-byte frame.
module printf_trace
  import printf_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter logic [7:0]  HDR_BYTE = DFLT_HDR_BYTE,
  localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
  input  logic           clock_in,
  input  logic           reset_in,
  input  logic [31:0]    outprintf1,
  input  logic [31:0]    outprintf2,
  input  logic [31:0]    outprintf3,
  input  logic [31:0]    printfext,
  input  logic [31:0]    printfula,
  input  logic           capture_in,
  output logic [7:0]     byte_out,
  output logic           byte_valid,
  input  logic           byte_ready,
  output logic [PTR_W:0] fifo_count,
  output logic           overflow,
  output logic [7:0]     drop_count,
  input  logic           clear_ovf
);

  state_e               state_q, state_d;
  logic [ENTRY_W-1:0]   frame_q, frame_d, head, entry;
  logic [4:0]           idx_q, idx_d;
  logic [7:0]           byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic [7:0]           seq_q, seq_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           drops_q, drops_d;
  logic                 fifo_full, fifo_empty, pop, accept, drop, hs;

  assign entry  = {seq_q, outprintf1, outprintf2, outprintf3, printfext, printfula};
  assign pop    = (state_q == StIdle) && !fifo_empty;
  assign accept = capture_in && (!fifo_full || pop);
  assign drop   = capture_in && !accept;
  assign hs     = valid_q && byte_ready;

  printf_trace_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .push    (accept),
    .pop     (pop),
    .wdata   (entry),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          frame_d = head;
          state_d = StLoad;
        end
      end
      StLoad: begin
        byte_d  = HDR_BYTE;
        valid_d = 1'b1;
        state_d = StHdr;
      end
      StHdr: begin
        if (hs) begin
          byte_d  = frame_q[ENTRY_W-1 -: 8];
          state_d = StSeq;
        end
      end
      StSeq: begin
        if (hs) begin
          idx_d   = 5'd0;
          byte_d  = data_byte(frame_q, 5'd0);
          state_d = StData;
        end
      end
      StData: begin
        if (hs) begin
          if (idx_q == 5'(DATA_BYTES - 1)) begin
            byte_d  = 8'h00;
            valid_d = 1'b0;
            state_d = StIdle;
          end else begin
            idx_d  = idx_q + 5'd1;
            byte_d = data_byte(frame_q, idx_q + 5'd1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A drop on the same edge as clear_ovf wins and restarts the count at one.
  always_comb begin
    seq_d   = accept ? seq_q + 8'd1 : seq_q;
    ovf_d   = ovf_q;
    drops_d = drops_q;
    if (drop) begin
      ovf_d   = 1'b1;
      drops_d = clear_ovf ? 8'd1 : ((drops_q == 8'hFF) ? drops_q : drops_q + 8'd1);
    end else if (clear_ovf) begin
      ovf_d   = 1'b0;
      drops_d = 8'd0;
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= StIdle;
      frame_q <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      seq_q   <= '0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign overflow   = ovf_q;
  assign drop_count = drops_q;

endmodule

// File: tb/tb_printf_trace.sv
// Bench for printf_trace: queue-based frame model checked every cycle plus directed literal checks.
module tb_printf_trace;

  localparam int DEPTH = 8;

  logic        clock_in = 1'b0;
  logic        reset_in = 1'b0;
  logic [31:0] outprintf1 = '0, outprintf2 = '0, outprintf3 = '0, printfext = '0, printfula = '0;
  logic        capture_in = 1'b0, byte_ready = 1'b0, clear_ovf = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;

  printf_trace #(
    .DEPTH   (DEPTH),
    .HDR_BYTE(8'hA5)
  ) dut (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .outprintf1(outprintf1),
    .outprintf2(outprintf2),
    .outprintf3(outprintf3),
    .printfext (printfext),
    .printfula (printfula),
    .capture_in(capture_in),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .drop_count(drop_count),
    .clear_ovf (clear_ovf)
  );

  always #5 clock_in = ~clock_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of snapshots, a transmitter that is idle, loading, or draining a byte list.
  logic [167:0] m_q[$];
  logic [167:0] m_cur;
  logic [7:0]   m_bytes[$];
  int           m_mode = 0;
  logic [7:0]   m_seq = 8'd0;
  logic         m_ovf = 1'b0;
  int           m_dc = 0;
  bit           m_pop, m_acc, m_drop;

  always @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      m_q.delete();
      m_bytes.delete();
      m_mode = 0;
      m_seq  = 8'd0;
      m_ovf  = 1'b0;
      m_dc   = 0;
    end else begin
      m_pop  = (m_mode == 0) && (m_q.size() > 0);
      m_acc  = capture_in && ((m_q.size() < DEPTH) || m_pop);
      m_drop = capture_in && !m_acc;
      if (m_pop) begin
        m_cur  = m_q.pop_front();
        m_mode = 1;
      end else if (m_mode == 1) begin
        m_bytes.push_back(8'hA5);
        m_bytes.push_back(m_cur[167:160]);
        for (int i = 0; i < 20; i++) m_bytes.push_back(m_cur[159 - 8 * i -: 8]);
        m_mode = 2;
      end else if (m_mode == 2 && byte_ready) begin
        void'(m_bytes.pop_front());
        if (m_bytes.size() == 0) m_mode = 0;
      end
      if (m_acc) begin
        m_q.push_back({m_seq, outprintf1, outprintf2, outprintf3, printfext, printfula});
        m_seq = m_seq + 8'd1;
      end
      if (m_drop) begin
        m_ovf = 1'b1;
        m_dc  = clear_ovf ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
      end else if (clear_ovf) begin
        m_ovf = 1'b0;
        m_dc  = 0;
      end
    end
  end

  // Per-cycle compare plus a log of accepted bytes and of each frame's seq byte.
  logic [7:0] got[$];
  logic [7:0] seqlog[$];
  int         pos = 0;

  always @(negedge clock_in) begin
    chk("byte_valid", 32'(byte_valid), 32'(m_mode == 2));
    if (m_mode == 2) chk("byte_out", 32'(byte_out), 32'(m_bytes[0]));
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_dc));
    if (!reset_in) pos = 0;
    else if (byte_valid && byte_ready) begin
      got.push_back(byte_out);
      if (pos == 1) seqlog.push_back(byte_out);
      pos = (pos == 21) ? 0 : pos + 1;
    end
  end

  task automatic step();
    @(posedge clock_in);
    #2;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(m_mode == 0 && m_q.size() == 0) && n < max) begin
      step();
      n++;
    end
    if (!(m_mode == 0 && m_q.size() == 0)) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_directed();
    outprintf1 = 32'h11223344;
    outprintf2 = 32'h55667788;
    outprintf3 = 32'h99AABBCC;
    printfext  = 32'hFFFFFFF0;
    printfula  = 32'h00000001;
  endtask

  task automatic set_random();
    outprintf1 = $urandom;
    outprintf2 = $urandom;
    outprintf3 = $urandom;
    printfext  = $urandom;
    printfula  = $urandom;
  endtask

  logic [7:0] exp_lit [22] = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                               8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hFF, 8'hFF,
                               8'hFF, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h01};

  initial begin
    int n;
    // Reset state
    repeat (2) step();
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte", 32'(byte_out), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    reset_in = 1'b1;
    step();

    // Single capture with ready held high, including header latency
    got.delete();
    set_directed();
    byte_ready = 1'b1;
    capture_in = 1'b1;
    step();
    capture_in = 1'b0;
    step();
    #4 chk("lat_k1_valid", 32'(byte_valid), 32'd0);
    step();
    #4 chk("lat_k2_valid", 32'(byte_valid), 32'd1);
    chk("lat_k2_hdr", 32'(byte_out), 32'hA5);
    wait_idle(100);
    chk("single_len", 32'(got.size()), 32'd22);
    for (int i = 0; i < 22; i++)
      if (i < got.size()) chk("single_byte", 32'(got[i]), 32'(exp_lit[i]));

    // Backpressure: stall 10 cycles on the header, then toggle ready
    got.delete();
    byte_ready = 1'b0;
    capture_in = 1'b1;
    step();
    capture_in = 1'b0;
    n = 0;
    while (m_mode != 2 && n < 10) begin step(); n++; end
    repeat (10) step();
    n = 0;
    while (m_mode != 0 && n < 200) begin
      byte_ready = ~byte_ready;
      step();
      n++;
    end
    chk("bp_len", 32'(got.size()), 32'd22);
    for (int i = 0; i < 22; i++)
      if (i < got.size()) chk("bp_byte", 32'(got[i]), (i == 1) ? 32'h01 : 32'(exp_lit[i]));

    // Reset during DATA idx 7 with one snapshot still queued
    byte_ready = 1'b1;
    capture_in = 1'b1;
    repeat (2) step();
    capture_in = 1'b0;
    n = 0;
    while (!(m_mode == 2 && m_bytes.size() == 13) && n < 50) begin step(); n++; end
    chk("idx7_byte", 32'(byte_out), 32'h88);
    chk("idx7_count", 32'(fifo_count), 32'd1);
    reset_in = 1'b0;
    #1;
    chk("async_valid", 32'(byte_valid), 32'd0);
    chk("async_count", 32'(fifo_count), 32'd0);
    repeat (2) step();
    reset_in = 1'b1;
    repeat (5) step();
    chk("post_rst_valid", 32'(byte_valid), 32'd0);

    // Overflow: 12 captures with the consumer stalled
    seqlog.delete();
    byte_ready = 1'b0;
    capture_in = 1'b1;
    repeat (12) step();
    capture_in = 1'b0;
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_count), 32'd3);
    byte_ready = 1'b1;
    n = 0;
    while (m_mode != 0 && n < 100) begin step(); n++; end
    chk("full_idle_count", 32'(fifo_count), 32'd8);
    capture_in = 1'b1;
    step();
    capture_in = 1'b0;
    chk("pushpop_count", 32'(fifo_count), 32'd8);
    chk("pushpop_drops", 32'(drop_count), 32'd3);
    wait_idle(400);
    chk("ovf_seq_len", 32'(seqlog.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < seqlog.size()) chk("ovf_seq", 32'(seqlog[i]), 32'(i));
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("clr_flag", 32'(overflow), 32'd0);
    chk("clr_drops", 32'(drop_count), 32'd0);

    // Drop and clear on the same edge: the drop wins
    byte_ready = 1'b0;
    capture_in = 1'b1;
    repeat (10) step();
    chk("pre_clr_drops", 32'(drop_count), 32'd1);
    capture_in = 1'b1;
    step();
    clear_ovf = 1'b1;
    step();
    capture_in = 1'b0;
    clear_ovf  = 1'b0;
    chk("dropclr_flag", 32'(overflow), 32'd1);
    chk("dropclr_drops", 32'(drop_count), 32'd1);
    byte_ready = 1'b1;
    wait_idle(400);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      set_random();
      capture_in = ($urandom_range(0, 99) < 30);
      byte_ready = ($urandom_range(0, 99) < 60);
      clear_ovf  = ($urandom_range(0, 99) < 3);
      step();
    end
    capture_in = 1'b0;
    clear_ovf  = 1'b0;
    byte_ready = 1'b1;
    wait_idle(400);

    // Sequence wrap over 257 frames, then clear after forced drops
    reset_in = 1'b0;
    step();
    reset_in = 1'b1;
    step();
    seqlog.delete();
    for (int c = 0; c < 257; c++) begin
      set_random();
      capture_in = 1'b1;
      step();
      capture_in = 1'b0;
      wait_idle(60);
    end
    chk("wrap_len", 32'(seqlog.size()), 32'd257);
    for (int i = 0; i < 257; i++)
      if (i < seqlog.size()) chk("wrap_seq", 32'(seqlog[i]), 32'(i % 256));
    byte_ready = 1'b0;
    capture_in = 1'b1;
    repeat (11) step();
    capture_in = 1'b0;
    chk("wrap_ovf", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("wrap_clr_flag", 32'(overflow), 32'd0);
    chk("wrap_clr_drops", 32'(drop_count), 32'd0);
    byte_ready = 1'b1;
    wait_idle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
